// File: rtl/cordic_phase_gen_pkg.sv
// Shared types and constants for the CORDIC phase sweep generator.
// Holds the degree type, adder width, default modulus and FSM encoding.
package cordic_phase_gen_pkg;

   localparam int DEG_MAX_DEF = 360;
   localparam int DEG_W       = 9;
   localparam int SUM_W       = 10;

   typedef logic [DEG_W-1:0] deg_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/cordic_phase_gen_phase_mod_add.sv
// Combinational modular add: a + b, folded back into 0..DEG_MAX-1.
// Both operands must already be below DEG_MAX, so one conditional subtract suffices.
module phase_mod_add
   import cordic_phase_gen_pkg::*;
#(
   parameter int DEG_MAX = DEG_MAX_DEF
) (
   input  logic [DEG_W-1:0] a_i,
   input  logic [DEG_W-1:0] b_i,
   output logic [DEG_W-1:0] sum_o,
   output logic             wrap_o
);

   logic [SUM_W-1:0] sum_raw;
   logic [SUM_W-1:0] sum_sub;

   assign sum_raw = {1'b0, a_i} + {1'b0, b_i};
   assign sum_sub = sum_raw - SUM_W'(DEG_MAX);
   assign wrap_o  = (sum_raw >= SUM_W'(DEG_MAX));

   always_comb begin
      sum_o = sum_raw[DEG_W-1:0];
      if (wrap_o) begin
         sum_o = sum_sub[DEG_W-1:0];
      end
   end

endmodule

// File: rtl/cordic_phase_gen.sv
// Phase sweep generator feeding a CORDIC: emits count phases init, init+step, ... mod DEG_MAX.
// One sample per accepted valid/ready transfer; all outputs are registered.
module cordic_phase_gen
   import cordic_phase_gen_pkg::*;
#(
   parameter int PHASE_W = 32,
   parameter int CNT_W   = 16,
   parameter int DEG_MAX = DEG_MAX_DEF
) (
   input  logic               CLK_50M,
   input  logic               RST_N,
   input  logic               start,
   input  logic               stop,
   input  logic [DEG_W-1:0]   init_phase,
   input  logic [DEG_W-1:0]   step,
   input  logic [CNT_W-1:0]   count,
   output logic [PHASE_W-1:0] Phase,
   output logic               phase_valid,
   input  logic               phase_ready,
   output logic               busy,
   output logic               done,
   output logic               wrap,
   output logic               cfg_err
);

   state_t           state_q, state_d;
   deg_t             phase_q, phase_d;
   deg_t             step_q, step_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             wrap_q, wrap_d;
   logic             cfg_err_q, cfg_err_d;

   deg_t             add_sum;
   logic             add_wrap;
   logic             cfg_ok;
   logic             xfer;

   phase_mod_add #(
      .DEG_MAX (DEG_MAX)
   ) u_add (
      .a_i    (phase_q),
      .b_i    (step_q),
      .sum_o  (add_sum),
      .wrap_o (add_wrap)
   );

   assign cfg_ok = ({1'b0, init_phase} < SUM_W'(DEG_MAX)) &&
                   ({1'b0, step} < SUM_W'(DEG_MAX)) &&
                   (count != '0);
   assign xfer   = valid_q & phase_ready;

   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q;
      step_d    = step_q;
      rem_d     = rem_q;
      done_d    = 1'b0;
      wrap_d    = 1'b0;
      cfg_err_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (cfg_ok) begin
                  step_d  = step;
                  phase_d = init_phase;
                  rem_d   = count;
                  state_d = ST_RUN;
               end else begin
                  cfg_err_d = 1'b1;
               end
            end
         end
         ST_RUN: begin
            if (xfer) begin
               rem_d = rem_q - CNT_W'(1);
               // The last sample stays on Phase; only earlier samples advance.
               if (rem_q == CNT_W'(1)) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else begin
                  phase_d = add_sum;
                  wrap_d  = add_wrap;
               end
            end
            if (stop) begin
               state_d = ST_IDLE;
               done_d  = 1'b0;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      valid_d = (state_d == ST_RUN);
      busy_d  = (state_d != ST_IDLE);
   end

   always_ff @(posedge CLK_50M or negedge RST_N) begin
      if (!RST_N) begin
         state_q   <= ST_IDLE;
         phase_q   <= '0;
         step_q    <= '0;
         rem_q     <= '0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         wrap_q    <= 1'b0;
         cfg_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         step_q    <= step_d;
         rem_q     <= rem_d;
         valid_q   <= valid_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         wrap_q    <= wrap_d;
         cfg_err_q <= cfg_err_d;
      end
   end

   assign Phase       = {{(PHASE_W-DEG_W){1'b0}}, phase_q};
   assign phase_valid = valid_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign wrap        = wrap_q;
   assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_cordic_phase_gen.sv
// Directed and randomized sweeps of cordic_phase_gen against a list-of-phases reference.
module tb_cordic_phase_gen;

   localparam int DEG = 360;

   logic        CLK_50M = 1'b0;
   logic        RST_N;
   logic        start, stop, phase_ready;
   logic [8:0]  init_phase, step;
   logic [15:0] count;
   logic [31:0] Phase;
   logic        phase_valid, busy, done, wrap, cfg_err;

   int n_pass  = 0;
   int n_total = 0;
   int n_fail  = 0;

   always #10 CLK_50M = ~CLK_50M;

   cordic_phase_gen dut (
      .CLK_50M     (CLK_50M),
      .RST_N       (RST_N),
      .start       (start),
      .stop        (stop),
      .init_phase  (init_phase),
      .step        (step),
      .count       (count),
      .Phase       (Phase),
      .phase_valid (phase_valid),
      .phase_ready (phase_ready),
      .busy        (busy),
      .done        (done),
      .wrap        (wrap),
      .cfg_err     (cfg_err)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK_50M);
      #1;
   endtask

   // Called #1 after the edge that accepted start; follows the sweep to the end.
   task automatic sweep_body(input int init, input int stp, input int cnt,
                             input int pct, input int low_first, input int stop_after);
      int  exp_ph[$];
      int  idx = 0;
      int  cycles = 0;
      bit  exp_wrap = 0;
      bit  rdy, stop_now;
      for (int k = 0; k < cnt; k++) exp_ph.push_back((init + k * stp) % DEG);
      while (idx < cnt && cycles < 4000) begin
         chk("valid_run", phase_valid, 1);
         chk("busy_run", busy, 1);
         chk("phase", Phase, exp_ph[idx]);
         chk("wrap", wrap, exp_wrap);
         chk("done_run", done, 0);
         rdy = (cycles < low_first) ? 1'b0 : ($urandom_range(0, 99) < pct);
         stop_now = (stop_after > 0) && rdy && (idx == stop_after - 1);
         phase_ready = rdy;
         stop = stop_now;
         tick();
         stop = 1'b0;
         cycles++;
         if (rdy) begin
            exp_wrap = (idx < cnt - 1) && (exp_ph[idx] + stp >= DEG);
            idx++;
            if (stop_now) begin
               chk("stop_valid", phase_valid, 0);
               chk("stop_busy", busy, 0);
               chk("stop_done", done, 0);
               chk("stop_phase", Phase, (init + stop_after * stp) % DEG);
               phase_ready = 1'b0;
               return;
            end
         end else begin
            exp_wrap = 1'b0;
         end
      end
      if (cycles >= 4000) begin
         chk("sweep_timeout", 0, 1);
         return;
      end
      phase_ready = 1'b0;
      chk("done_pulse", done, 1);
      chk("done_valid", phase_valid, 0);
      chk("done_busy", busy, 1);
      chk("done_wrap", wrap, 0);
      chk("done_phase", Phase, exp_ph[cnt-1]);
      tick();
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
   endtask

   task automatic run_sweep(input int init, input int stp, input int cnt,
                            input int pct, input int low_first, input int stop_after);
      start = 1'b1;
      init_phase = 9'(init);
      step = 9'(stp);
      count = 16'(cnt);
      tick();
      start = 1'b0;
      sweep_body(init, stp, cnt, pct, low_first, stop_after);
   endtask

   task automatic bad_start(input int init, input int stp, input int cnt, input int keep_phase);
      start = 1'b1;
      init_phase = 9'(init);
      step = 9'(stp);
      count = 16'(cnt);
      tick();
      start = 1'b0;
      chk("cfg_err_pulse", cfg_err, 1);
      chk("cfg_err_busy", busy, 0);
      chk("cfg_err_valid", phase_valid, 0);
      chk("cfg_err_phase", Phase, keep_phase);
      tick();
      chk("cfg_err_clear", cfg_err, 0);
      chk("cfg_err_idle", busy, 0);
   endtask

   initial begin
      int r_init, r_step, r_cnt;
      RST_N = 1'b0;
      start = 1'b0;
      stop = 1'b0;
      phase_ready = 1'b0;
      init_phase = '0;
      step = '0;
      count = '0;
      repeat (2) @(posedge CLK_50M);
      #1;
      chk("rst_phase", Phase, 0);
      chk("rst_valid", phase_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_wrap", wrap, 0);
      chk("rst_cfg_err", cfg_err, 0);
      @(negedge CLK_50M);
      RST_N = 1'b1;
      tick();

      run_sweep(60, 0, 3, 100, 0, 0);
      run_sweep(350, 15, 3, 100, 0, 0);
      run_sweep(0, 90, 4, 100, 5, 0);

      bad_start(10, 400, 5, 270);
      bad_start(10, 20, 0, 270);
      bad_start(360, 20, 5, 270);

      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("stop_idle_busy", busy, 0);
      chk("stop_idle_valid", phase_valid, 0);

      run_sweep(100, 37, 100, 100, 0, 10);

      for (int i = 0; i < 6; i++) begin
         r_init = $urandom_range(0, DEG - 1);
         r_step = $urandom_range(0, DEG - 1);
         r_cnt  = $urandom_range(1, 8);
         run_sweep(r_init, r_step, r_cnt, 60, 0, 0);
      end

      start = 1'b1;
      init_phase = 9'd200;
      step = 9'd50;
      count = 16'd20;
      tick();
      start = 1'b0;
      phase_ready = 1'b1;
      repeat (3) tick();
      RST_N = 1'b0;
      #2;
      chk("arst_phase", Phase, 0);
      chk("arst_valid", phase_valid, 0);
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      chk("arst_wrap", wrap, 0);
      chk("arst_cfg_err", cfg_err, 0);
      @(negedge CLK_50M);
      RST_N = 1'b1;
      phase_ready = 1'b0;
      start = 1'b1;
      init_phase = 9'd45;
      step = 9'd120;
      count = 16'd5;
      tick();
      start = 1'b0;
      sweep_body(45, 120, 5, 70, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
